set3_reverse_conv: RTL and testbench

Multi-cycle residue-to-binary converter for the moduli set {2^(n+1)−1, 2^n, 2^n−1}, matching the residue formats produced by `set3_mult`. It accepts one residue triple through a valid/ready handshake and reconstructs the binary integer X in [0, M−1] using mixed-radix conversion built only from end-around subtractors and rotations. The result is returned through a second valid/ready handshake. It sits at the output of the RNS datapath and feeds binary consumers such as activation and accumulation.

---
 rtl/rns_pkg.sv | 25 ++
 rtl/set3_mod_sub.sv | 25 ++
 rtl/set3_reverse_conv.sv | 114 +++++++++++
 tb/tb_set3_reverse_conv.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared definitions for the {2^(n+1)-1, 2^n, 2^n-1} residue datapath:
// converter FSM encoding and width helpers.
package rns_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_Y,
        S_Z,
        S_X,
        DONE
    } conv_state_t;

    function automatic int w1(input int n);
        return n + 1;
    endfunction

    function automatic int wx(input int n);
        return 3 * n + 1;
    endfunction

    // Dynamic range for n = 4: 31 * 16 * 15
    localparam int N_BENCH = 4;
    localparam int M_BENCH = 7440;

endpackage

// File: rtl/set3_mod_sub.sv
// Combinational a - b mod (2^k - 1) using end-around carry.
// Operands and result are canonical: all-ones is treated as, and mapped to, zero.
module set3_mod_sub #(
    parameter int k = 4
) (
    input  logic [k-1:0] a,
    input  logic [k-1:0] b,
    output logic [k-1:0] d
);

    logic [k-1:0] a_norm;
    logic [k-1:0] b_norm;
    logic [k:0]   sum;
    logic [k-1:0] wrapped;

    always_comb begin
        a_norm  = (a == '1) ? '0 : a;
        b_norm  = (b == '1) ? '0 : b;
        sum     = {1'b0, a_norm} + {1'b0, ~b_norm};
        // Carry-out folds back in; it cannot overflow a second time.
        wrapped = sum[k-1:0] + k'(sum[k]);
        d       = (wrapped == '1) ? '0 : wrapped;
    end

endmodule

// File: rtl/set3_reverse_conv.sv
// Residue-to-binary converter for {2^(n+1)-1, 2^n, 2^n-1} by mixed-radix
// conversion: one residue triple in, one binary integer out, no overlap.
module set3_reverse_conv
    import rns_pkg::*;
#(
    parameter int n = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [n:0]        r1,
    input  logic [n-1:0]      r2,
    input  logic [n-1:0]      r3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3*n:0]      x
);

    localparam int W1 = w1(n);
    localparam int WX = wx(n);

    conv_state_t     state;
    conv_state_t     state_next;

    logic [W1-1:0]   r1_q;
    logic [n-1:0]    r2_q;
    logic [n-1:0]    r3_q;
    logic [n-1:0]    y3_q;
    logic [W1-1:0]   y1_q;
    logic [W1-1:0]   z_q;
    logic [WX-1:0]   x_q;

    logic [n-1:0]    y3_d;
    logic [W1-1:0]   sub_a;
    logic [W1-1:0]   sub_b;
    logic [W1-1:0]   sub_d;
    logic [W1-1:0]   sub_rot;
    logic [WX-1:0]   mix;
    logic [WX-1:0]   x_d;

    set3_mod_sub #(.k(n)) u_sub_m3 (
        .a (r3_q),
        .b (r2_q),
        .d (y3_d)
    );

    // One mod-m1 subtractor shared between S_Y (y1) and S_Z (z).
    set3_mod_sub #(.k(W1)) u_sub_m1 (
        .a (sub_a),
        .b (sub_b),
        .d (sub_d)
    );

    // Rotate-left-by-one is multiplication by 2 mod 2^(n+1)-1.
    assign sub_rot = {sub_d[W1-2:0], sub_d[W1-1]};

    always_comb begin
        sub_a = r1_q;
        sub_b = {1'b0, r2_q};
        if (state == S_Z) begin
            sub_a = {1'b0, y3_q};
            sub_b = y1_q;
        end
        mix = WX'(y3_q) + (WX'(z_q) << n) - WX'(z_q);
        x_d = WX'(r2_q) + (mix << n);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = S_Y;
            S_Y:     state_next = S_Z;
            S_Z:     state_next = S_X;
            S_X:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
            y3_q  <= '0;
            y1_q  <= '0;
            z_q   <= '0;
            x_q   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: if (in_valid) begin
                    r1_q <= r1;
                    r2_q <= r2;
                    r3_q <= r3;
                end
                S_Y: begin
                    y3_q <= y3_d;
                    y1_q <= sub_rot;
                end
                S_Z:     z_q <= sub_rot;
                S_X:     x_q <= x_d;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign x         = x_q;

endmodule

// File: tb/tb_set3_reverse_conv.sv
// Scoreboard bench for set3_reverse_conv at n = 4 (moduli 31, 16, 15).
module tb_set3_reverse_conv;
    import rns_pkg::*;

    localparam int N = 4;
    localparam int M = M_BENCH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N:0]    r1 = '0;
    logic [N-1:0]  r2 = '0;
    logic [N-1:0]  r3 = '0;
    logic          out_valid;
    logic          out_ready;
    logic [3*N:0]  x;

    int checks = 0;
    int fails = 0;
    int outputs_seen = 0;
    int ready_mode = 1;     // 0: hold low, 1: hold high, 2: random
    int expq[$];

    set3_reverse_conv #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x)
    );

    always #5 clk = ~clk;

    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the unique X in [0, M) whose residues match (all-ones counts as 0).
    function automatic int crt(input int a, input int b, input int c);
        for (int v = 0; v < M; v++)
            if (v % 31 == a % 31 && v % 16 == b && v % 15 == c % 15) return v;
        return -1;
    endfunction

    // Monitor: a handshake happens at the next rising edge when both are high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            outputs_seen++;
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_output: got %0d expected none", x);
            end else begin
                chk("x", 32'(x), 32'(expq.pop_front()));
            end
        end
    end

    // Called in the posedge+#1 phase; returns in the same phase after acceptance.
    task automatic send(input int a, input int b, input int c, input int exp, input bit track);
        int t;
        t = 0;
        r1 = (N+1)'(a);
        r2 = N'(b);
        r3 = N'(c);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 32'(t), 0);
                break;
            end
            @(posedge clk); #1;
        end
        if (track && t <= 200) expq.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", 32'(expq.size()), 0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int v, a, c;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_x", 32'(x), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic conversion with latency check: out_valid after the third edge.
        ready_mode = 1;
        send(8, 8, 10, crt(8, 8, 10), 1'b1);
        chk("model_1000", 32'(crt(8, 8, 10)), 1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("latency_valid", 32'(out_valid), (i == 3) ? 1 : 0);
        end
        @(posedge clk); #1;
        drain();

        send(30, 15, 14, 7439, 1'b1);
        send(31, 0, 15, 0, 1'b1);
        send(0, 0, 0, 0, 1'b1);
        send(30, 0, 0, crt(30, 0, 0), 1'b1);
        drain();

        // Backpressure: result held, new requests refused.
        ready_mode = 0;
        @(posedge clk); #1;
        send(9, 8, 5, 5000, 1'b1);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk("bp_reach_valid", 32'(out_valid), 1);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            r1 = 5'd3; r2 = 4'd3; r3 = 4'd3;
            @(negedge clk);
            chk("bp_x", 32'(x), 5000);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ready_mode = 1;
        @(posedge clk); #1;
        drain();
        repeat (8) @(posedge clk);
        #1;
        chk("bp_no_extra_accept", 32'(expq.size()), 0);

        // Reset while the converter is in S_Z.
        seen = outputs_seen;
        send(8, 8, 10, 1000, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_x", 32'(x), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_output", 32'(outputs_seen), 32'(seen));

        // Full sweep with random stalls and redundant zero encodings.
        ready_mode = 2;
        for (int xv = 0; xv < M; xv++) begin
            v = xv;
            a = v % 31;
            c = v % 15;
            if (a == 0 && $urandom_range(0, 1) == 1) a = 31;
            if (c == 0 && $urandom_range(0, 1) == 1) c = 15;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(a, v % 16, c, v, 1'b1);
        end
        ready_mode = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
